// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared BCD types, widths and FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;
   localparam int BCD_DIGIT_W   = 4;
   localparam int BCD_MAX_DIGIT = 9;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } bcd_sub_state_t;
endpackage

`default_nettype wire

// File: rtl/bcd_digit_sub.sv
// ============================================================================
// Module  : bcd_digit_sub
// Brief   : Combinational single-digit BCD subtract with borrow in/out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_sub
   import bcd_pkg::*;
(
   input  bcd_digit_t a_i,
   input  bcd_digit_t b_i,
   input  logic       bin_i,
   output bcd_digit_t d_o,
   output logic       bout_o
);

   logic [BCD_DIGIT_W:0] raw;

   // A negative raw difference wraps modulo 16; adding ten yields the decimal digit.
   always_comb begin
      raw    = {1'b0, a_i} - {1'b0, b_i} - {{BCD_DIGIT_W{1'b0}}, bin_i};
      bout_o = raw[BCD_DIGIT_W];
      d_o    = bout_o ? (raw[BCD_DIGIT_W-1:0] + bcd_digit_t'(10)) : raw[BCD_DIGIT_W-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/bcd_subtractor_seq.sv
// ============================================================================
// Module  : bcd_subtractor_seq
// Brief   : Digit-serial BCD subtractor, |a-b| plus sign, valid/ready on both sides.
//           Optional input-digit check enabled by macro BCD_SUB_INVALID_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_subtractor_seq
   import bcd_pkg::*;
#(
   parameter int NDIG = 3
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [BCD_DIGIT_W*NDIG-1:0] in_a_i,
   input  logic [BCD_DIGIT_W*NDIG-1:0] in_b_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [BCD_DIGIT_W*NDIG-1:0] diff_o,
   output logic                        neg_o,
   output logic                        err_o
);

   localparam int                W        = BCD_DIGIT_W * NDIG;
   localparam int                CNT_W    = $clog2(NDIG + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NDIG - 1);

   bcd_sub_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     a_q, b_q, r_q, diff_q;
   logic             borrow_q, neg_q;
   logic             err_w;
   logic             last_w;
   bcd_digit_t       op_a, op_b, dig;
   logic             bout;
   logic [W+BCD_DIGIT_W-1:0] r_ext;
   logic [W-1:0]     r_shift;

   // One digit slice serves both the subtract pass and the ten's-complement pass.
   assign op_a    = (state_q == NEG) ? bcd_digit_t'(0) : a_q[BCD_DIGIT_W-1:0];
   assign op_b    = (state_q == NEG) ? r_q[BCD_DIGIT_W-1:0] : b_q[BCD_DIGIT_W-1:0];
   assign last_w  = (cnt_q == CNT_LAST);
   assign r_ext   = {dig, r_q};
   assign r_shift = r_ext[W+BCD_DIGIT_W-1:BCD_DIGIT_W];

   bcd_digit_sub u_digit_sub (
      .a_i    (op_a),
      .b_i    (op_b),
      .bin_i  (borrow_q),
      .d_o    (dig),
      .bout_o (bout)
   );

`ifdef BCD_SUB_INVALID_CHK_EN
   logic err_q;
   logic inv_w;

   always_comb begin
      inv_w = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if ((in_a_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > bcd_digit_t'(BCD_MAX_DIGIT)) ||
             (in_b_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > bcd_digit_t'(BCD_MAX_DIGIT)))
            inv_w = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (state_q == IDLE && in_valid_i)
         err_q <= inv_w;
   end

   assign err_w = err_q;
`else
   assign err_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid_i) state_d = SUB;
         SUB:  if (last_w)     state_d = (bout && !err_w) ? NEG : DONE;
         NEG:  if (last_w)     state_d = DONE;
         DONE: if (out_ready_i) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
      diff_o      = diff_q;
      neg_o       = neg_q;
      err_o       = err_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q      <= in_a_i;
                  b_q      <= in_b_i;
                  cnt_q    <= '0;
                  borrow_q <= 1'b0;
                  neg_q    <= 1'b0;
               end
            end
            SUB: begin
               a_q      <= a_q >> BCD_DIGIT_W;
               b_q      <= b_q >> BCD_DIGIT_W;
               r_q      <= r_shift;
               borrow_q <= bout;
               cnt_q    <= last_w ? '0 : cnt_q + 1'b1;
               if (last_w) begin
                  if (bout && !err_w) begin
                     neg_q    <= 1'b1;
                     borrow_q <= 1'b0;
                  end else begin
                     diff_q <= err_w ? '0 : r_shift;
                  end
               end
            end
            NEG: begin
               r_q      <= r_shift;
               borrow_q <= bout;
               cnt_q    <= last_w ? '0 : cnt_q + 1'b1;
               if (last_w)
                  diff_q <= r_shift;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
